// File: rtl/sequence_gen_pkg.sv
// Shared definitions for the serial sequence generator and any matching
// detector: FSM state encoding, default width, the built-in default
// pattern/length, and a length-legality helper.
package sequence_gen_pkg;

    // Maximum pattern length in bits.
    localparam int SEQ_W = 8;
    // Width of the length / repeat / gap fields and of the internal counters.
    localparam int SEQ_CNT_W = 4;
    // Pattern and length used when use_default is high at start.
    localparam logic [SEQ_W-1:0] SEQ_DEFAULT_PATTERN = 8'b0000_1011;
    localparam int SEQ_DEFAULT_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // A pattern length is usable when it is non-zero and fits the pattern register.
    function automatic logic seq_len_legal(input logic [SEQ_CNT_W-1:0] len, input int max_len);
        return (len != 4'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/sequence_gen_down_counter.sv
// sequence_down_counter: loadable down-counter with a zero flag.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   load/load_val : load a new count (load wins over dec)
//   dec           : decrement by one; saturates at zero, never wraps
//   count, zero   : registered count and (count == 0) flag
module sequence_down_counter #(
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    // Next count: load has priority, decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/sequence_gen.sv
// sequence_gen: serialises a latched pattern MSB-first (pattern[pat_len-1]
// first) with valid/ready handshaking, repeat_cnt+1 repetitions separated by
// gap_len idle cycles, then a one-cycle done pulse. All outputs registered.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, use_default  : begin a transmission (IDLE only), optionally with
//                         the built-in pattern/length
//   pattern, pat_len    : bits to send and number of bits per repetition
//   repeat_cnt, gap_len : extra repetitions, idle cycles between repetitions
//   abort               : cancel any transmission, back to IDLE
//   sequence_ready      : consumer accepts the current bit
//   sequence_out/valid  : serial bit and its qualifier
//   busy, done, err     : not-IDLE, end-of-transfer pulse, rejected-start pulse
module sequence_gen
    import sequence_gen_pkg::*;
#(
    parameter int             W               = SEQ_W,
    parameter logic [W-1:0]   DEFAULT_PATTERN = W'(SEQ_DEFAULT_PATTERN),
    parameter int             DEFAULT_LEN     = SEQ_DEFAULT_LEN
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 use_default,
    input  logic [W-1:0]         pattern,
    input  logic [SEQ_CNT_W-1:0] pat_len,
    input  logic [SEQ_CNT_W-1:0] repeat_cnt,
    input  logic [SEQ_CNT_W-1:0] gap_len,
    input  logic                 abort,
    input  logic                 sequence_ready,
    output logic                 sequence_out,
    output logic                 sequence_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    seq_state_e           state_d, state_q;
    logic [W-1:0]         pat_d, pat_q;
    logic [SEQ_CNT_W-1:0] len_d, len_q;
    logic [SEQ_CNT_W-1:0] gap_d, gap_q;
    logic                 out_d, out_q;
    logic                 valid_d, valid_q;
    logic                 busy_d, busy_q;
    logic                 done_d, done_q;
    logic                 err_d, err_q;

    logic [W-1:0]         eff_pat_s;
    logic [SEQ_CNT_W-1:0] eff_len_s;
    logic                 accept_s;

    logic                 bit_load_s, bit_dec_s, bit_zero_s;
    logic [SEQ_CNT_W-1:0] bit_load_val_s, bit_cnt_s;
    logic                 rep_load_s, rep_dec_s, rep_zero_s;
    logic [SEQ_CNT_W-1:0] rep_cnt_s;
    logic                 gap_load_s, gap_dec_s, gap_zero_s;
    logic [SEQ_CNT_W-1:0] gap_cnt_s;
    logic                 unused_cnt_s;

    // Select bit idx of p; a shift keeps any index width legal.
    function automatic logic bit_of(input logic [W-1:0] p, input logic [SEQ_CNT_W-1:0] idx);
        logic [W-1:0] sh;
        sh = p >> idx;
        return sh[0];
    endfunction

    assign eff_pat_s = use_default ? DEFAULT_PATTERN : pattern;
    assign eff_len_s = use_default ? SEQ_CNT_W'(DEFAULT_LEN) : pat_len;
    assign accept_s  = valid_q && sequence_ready;

    // Bit index: counts down from len-1; zero marks the last bit of a repetition.
    sequence_down_counter #(.CW(SEQ_CNT_W)) u_bit_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (bit_load_s),
        .load_val (bit_load_val_s),
        .dec      (bit_dec_s),
        .count    (bit_cnt_s),
        .zero     (bit_zero_s)
    );

    // Remaining extra repetitions; zero means the current repetition is the last.
    sequence_down_counter #(.CW(SEQ_CNT_W)) u_rep_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (rep_load_s),
        .load_val (repeat_cnt),
        .dec      (rep_dec_s),
        .count    (rep_cnt_s),
        .zero     (rep_zero_s)
    );

    // Gap cycles left minus one; loaded with gap_len-1 so zero marks the final gap cycle.
    sequence_down_counter #(.CW(SEQ_CNT_W)) u_gap_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (gap_load_s),
        .load_val (gap_q - 4'd1),
        .dec      (gap_dec_s),
        .count    (gap_cnt_s),
        .zero     (gap_zero_s)
    );

    // Only the zero flags of the repeat and gap counters steer the FSM.
    assign unused_cnt_s = ^{rep_cnt_s, gap_cnt_s};

    // Next-state, latched parameters, counter control and next output values.
    always_comb begin
        state_d        = state_q;
        pat_d          = pat_q;
        len_d          = len_q;
        gap_d          = gap_q;
        out_d          = out_q;
        err_d          = 1'b0;
        bit_load_s     = 1'b0;
        bit_load_val_s = len_q - 4'd1;
        bit_dec_s      = 1'b0;
        rep_load_s     = 1'b0;
        rep_dec_s      = 1'b0;
        gap_load_s     = 1'b0;
        gap_dec_s      = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_d = 1'b0;
                    if (start) begin
                        if (seq_len_legal(eff_len_s, W)) begin
                            state_d        = ST_SEND;
                            pat_d          = eff_pat_s;
                            len_d          = eff_len_s;
                            gap_d          = gap_len;
                            bit_load_s     = 1'b1;
                            bit_load_val_s = eff_len_s - 4'd1;
                            rep_load_s     = 1'b1;
                            out_d          = bit_of(eff_pat_s, eff_len_s - 4'd1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (accept_s) begin
                        if (!bit_zero_s) begin
                            bit_dec_s = 1'b1;
                            out_d     = bit_of(pat_q, bit_cnt_s - 4'd1);
                        end else if (rep_zero_s) begin
                            state_d = ST_DONE;
                            out_d   = 1'b0;
                        end else if (gap_q != 4'd0) begin
                            rep_dec_s  = 1'b1;
                            gap_load_s = 1'b1;
                            state_d    = ST_GAP;
                            out_d      = 1'b0;
                        end else begin
                            // Back-to-back repetition: first bit follows the last with no bubble.
                            rep_dec_s  = 1'b1;
                            bit_load_s = 1'b1;
                            out_d      = bit_of(pat_q, len_q - 4'd1);
                        end
                    end else begin
                        out_d = out_q;
                    end
                end
                ST_GAP: begin
                    out_d = 1'b0;
                    if (gap_zero_s) begin
                        state_d    = ST_SEND;
                        bit_load_s = 1'b1;
                        out_d      = bit_of(pat_q, len_q - 4'd1);
                    end else begin
                        gap_dec_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                end
            endcase
        end

        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // FSM state, latched parameters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign sequence_out   = out_q;
    assign sequence_valid = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_sequence_gen.sv
// Self-checking bench for sequence_gen: expected bits are queued when a start
// is driven and popped on every accepted bit; a 1011 detector runs on the
// accepted stream; scenario tasks check framing, gaps, stalls, errors,
// abort and reset.
module tb_sequence_gen;
    import sequence_gen_pkg::*;

    logic       clock = 1'b0;
    logic       reset, start, use_default, abort, sequence_ready;
    logic [7:0] pattern;
    logic [3:0] pat_len, repeat_cnt, gap_len;
    logic       sequence_out, sequence_valid, busy, done, err;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    logic held_q[$];
    logic exp_b;
    int   accepted;
    logic [3:0] det_hist;
    int   det_fill, det_hits;

    always #5 clock = ~clock;

    sequence_gen #(.W(8), .DEFAULT_PATTERN(8'b0000_1011), .DEFAULT_LEN(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .use_default    (use_default),
        .pattern        (pattern),
        .pat_len        (pat_len),
        .repeat_cnt     (repeat_cnt),
        .gap_len        (gap_len),
        .abort          (abort),
        .sequence_ready (sequence_ready),
        .sequence_out   (sequence_out),
        .sequence_valid (sequence_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    // Scoreboard and 1011 detector on accepted bits; stalled bits are recorded.
    always @(negedge clock) begin
        if (sequence_valid === 1'b1 && sequence_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got bit %b, expected no bit", sequence_out);
            end else begin
                exp_b = exp_q.pop_front();
                if (sequence_out !== exp_b) begin
                    bad++;
                    $display("FAIL sb_bit%0d: got %b, expected %b", accepted, sequence_out, exp_b);
                end
            end
            accepted++;
            det_hist = {det_hist[2:0], sequence_out};
            if (det_fill < 4) det_fill++;
            if (det_fill >= 4 && det_hist == 4'b1011) det_hits++;
        end else if (sequence_valid === 1'b1) begin
            held_q.push_back(sequence_out);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one start and queue the bits the bench expects for it.
    task automatic start_xfer(input logic ud, input logic [7:0] pat, input logic [3:0] len,
                              input logic [3:0] rep, input logic [3:0] gap);
        logic [7:0] mp;
        logic [3:0] ml;
        mp = ud ? 8'h0B : pat;
        ml = ud ? 4'd4 : len;
        exp_q.delete();
        held_q.delete();
        accepted = 0;
        det_hist = 4'd0;
        det_fill = 0;
        det_hits = 0;
        for (int r = 0; r <= int'(rep); r++)
            for (int i = int'(ml) - 1; i >= 0; i--) exp_q.push_back(mp[i]);
        use_default = ud;
        pattern     = pat;
        pat_len     = len;
        repeat_cnt  = rep;
        gap_len     = gap;
        start       = 1'b1;
        step();
        start       = 1'b0;
        use_default = 1'b0;
        pattern     = 8'($urandom);
        pat_len     = 4'($urandom_range(1, 8));
        repeat_cnt  = 4'($urandom);
        gap_len     = 4'($urandom);
    endtask

    // Run until done (bounded), optionally stalling ready on one bit index.
    task automatic run_xfer(input int max_cycles, input int stall_idx, input int stall_len,
                            output int cycles, output bit got_done, output string trace);
        int left;
        left     = stall_len;
        cycles   = 0;
        got_done = 1'b0;
        trace    = "";
        while (cycles < max_cycles) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            trace = {trace, (sequence_valid === 1'b1) ? "1" : "0"};
            if (sequence_valid === 1'b1 && accepted == stall_idx && left > 0) begin
                sequence_ready = 1'b0;
                left--;
            end else begin
                sequence_ready = 1'b1;
            end
            cycles++;
            step();
        end
        sequence_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b1; use_default = 1'b1;
        step(); step();
        total++;
        if ({sequence_out, sequence_valid, busy, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, expected 00000",
                     {sequence_out, sequence_valid, busy, done, err});
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; use_default = 1'b0;
        step();
        total++;
        if ({sequence_valid, busy, done, err} !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle: got %b, expected 0000", {sequence_valid, busy, done, err});
        end
    endtask

    task automatic test_default();
        int cyc; bit gd; string tr;
        start_xfer(1'b1, 8'hF0, 4'd15, 4'd0, 4'd0);
        run_xfer(40, -1, 0, cyc, gd, tr);
        total++;
        if (!gd || tr != "1111") begin
            bad++; $display("FAIL default_frame: got done=%0d trace=%s, expected done=1 trace=1111", gd, tr);
        end
        total++;
        if (det_hits != 1 || exp_q.size() != 0) begin
            bad++; $display("FAIL default_detect: got hits=%0d left=%0d, expected hits=1 left=0", det_hits, exp_q.size());
        end
        total++;
        if ({busy, sequence_valid} !== 2'b10) begin
            bad++; $display("FAIL default_done_state: got busy,valid=%b, expected 10", {busy, sequence_valid});
        end
        step();
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++; $display("FAIL default_after_done: got done,busy=%b, expected 00", {done, busy});
        end
    endtask

    task automatic test_gap();
        int cyc; bit gd; string tr;
        start_xfer(1'b0, 8'hA5, 4'd8, 4'd1, 4'd2);
        run_xfer(60, -1, 0, cyc, gd, tr);
        total++;
        if (!gd || tr != "111111110011111111" || exp_q.size() != 0) begin
            bad++; $display("FAIL gap_frame: got done=%0d trace=%s left=%0d, expected done=1 trace=111111110011111111 left=0",
                            gd, tr, exp_q.size());
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc; bit gd; string tr;
        start_xfer(1'b1, 8'h00, 4'd0, 4'd2, 4'd0);
        run_xfer(60, -1, 0, cyc, gd, tr);
        total++;
        if (!gd || tr != "111111111111" || det_hits != 3) begin
            bad++; $display("FAIL b2b_frame: got done=%0d trace=%s hits=%0d, expected done=1 trace=111111111111 hits=3",
                            gd, tr, det_hits);
        end
        step();
    endtask

    task automatic test_stall();
        int cyc; bit gd; string tr; int held_bad;
        start_xfer(1'b1, 8'h00, 4'd0, 4'd0, 4'd0);
        run_xfer(40, 2, 3, cyc, gd, tr);
        total++;
        if (!gd || cyc != 7) begin
            bad++; $display("FAIL stall_length: got done=%0d cycles=%0d, expected done=1 cycles=7", gd, cyc);
        end
        held_bad = 0;
        foreach (held_q[i]) if (held_q[i] !== 1'b1) held_bad++;
        total++;
        if (held_q.size() != 3 || held_bad != 0) begin
            bad++; $display("FAIL stall_hold: got held=%0d unstable=%0d, expected held=3 unstable=0", held_q.size(), held_bad);
        end
        step();
    endtask

    task automatic test_rep15();
        int cyc; bit gd; string tr;
        start_xfer(1'b0, 8'h01, 4'd1, 4'd15, 4'd0);
        run_xfer(60, -1, 0, cyc, gd, tr);
        total++;
        if (!gd || tr != "1111111111111111") begin
            bad++; $display("FAIL rep15_frame: got done=%0d trace=%s, expected 16 valid cycles then done", gd, tr);
        end
        step();
    endtask

    task automatic test_err();
        int cyc; bit gd; string tr; int errs;
        logic [3:0] lens [2];
        lens[0] = 4'd0;
        lens[1] = 4'd9;
        for (int k = 0; k < 2; k++) begin
            use_default = 1'b0; pattern = 8'hFF; pat_len = lens[k]; start = 1'b1;
            step();
            start = 1'b0;
            total++;
            if ({err, busy, sequence_valid} !== 3'b100) begin
                bad++; $display("FAIL err_pulse_len%0d: got err,busy,valid=%b, expected 100", lens[k], {err, busy, sequence_valid});
            end
            step();
            total++;
            if ({err, busy} !== 2'b00) begin
                bad++; $display("FAIL err_clear_len%0d: got err,busy=%b, expected 00", lens[k], {err, busy});
            end
        end
        // Start while busy: both an illegal and a legal start must be ignored.
        start_xfer(1'b0, 8'hC3, 4'd8, 4'd0, 4'd0);
        errs = 0;
        pattern = 8'h0F; pat_len = 4'd0; start = 1'b1;
        step();
        pat_len = 4'd4;
        step();
        if (err === 1'b1) errs++;
        start = 1'b0;
        step();
        if (err === 1'b1) errs++;
        run_xfer(40, -1, 0, cyc, gd, tr);
        total++;
        if (!gd || errs != 0 || exp_q.size() != 0) begin
            bad++; $display("FAIL busy_start: got done=%0d errs=%0d left=%0d, expected done=1 errs=0 left=0", gd, errs, exp_q.size());
        end
        step();
    endtask

    task automatic test_abort();
        int cyc; bit gd; string tr; int n; int dones;
        start_xfer(1'b0, 8'hA5, 4'd8, 4'd0, 4'd0);
        n = 0;
        while (accepted < 3 && n < 20) begin
            sequence_ready = 1'b1;
            step();
            n++;
        end
        sequence_ready = 1'b0;
        abort = 1'b1; start = 1'b1; use_default = 1'b1;
        step();
        abort = 1'b0; start = 1'b0; use_default = 1'b0; sequence_ready = 1'b1;
        total++;
        if ({sequence_valid, busy, done} !== 3'b000 || accepted != 3) begin
            bad++; $display("FAIL abort_idle: got valid,busy,done=%b accepted=%0d, expected 000 accepted=3",
                            {sequence_valid, busy, done}, accepted);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL abort_quiet: got %0d busy/done cycles, expected 0", dones);
        end
        exp_q.delete();
        start_xfer(1'b1, 8'h00, 4'd0, 4'd0, 4'd0);
        run_xfer(40, -1, 0, cyc, gd, tr);
        total++;
        if (!gd || tr != "1111") begin
            bad++; $display("FAIL abort_restart: got done=%0d trace=%s, expected done=1 trace=1111", gd, tr);
        end
        step();
    endtask

    task automatic test_reset_gap();
        int cyc; bit gd; string tr; int n;
        start_xfer(1'b0, 8'hA5, 4'd8, 4'd1, 4'd3);
        n = 0;
        while (!(sequence_valid === 1'b0 && busy === 1'b1 && accepted == 8) && n < 30) begin
            step();
            n++;
        end
        total++;
        if (n >= 30) begin
            bad++; $display("FAIL gap_reach: got no gap within 30 cycles, expected gap after 8 bits");
        end
        reset = 1'b1;
        step();
        total++;
        if ({sequence_out, sequence_valid, busy, done, err} !== 5'b0) begin
            bad++; $display("FAIL gap_reset_outputs: got %b, expected 00000", {sequence_out, sequence_valid, busy, done, err});
        end
        reset = 1'b0;
        step();
        total++;
        if ({sequence_valid, busy, done} !== 3'b000) begin
            bad++; $display("FAIL gap_reset_idle: got valid,busy,done=%b, expected 000", {sequence_valid, busy, done});
        end
        exp_q.delete();
        start_xfer(1'b0, 8'h35, 4'd6, 4'd1, 4'd1);
        run_xfer(40, -1, 0, cyc, gd, tr);
        total++;
        if (!gd || tr != "1111110111111" || exp_q.size() != 0) begin
            bad++; $display("FAIL gap_reset_restart: got done=%0d trace=%s left=%0d, expected done=1 trace=1111110111111 left=0",
                            gd, tr, exp_q.size());
        end
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; use_default = 1'b0; abort = 1'b0; sequence_ready = 1'b1;
        pattern = 8'h00; pat_len = 4'd0; repeat_cnt = 4'd0; gap_len = 4'd0;
        accepted = 0; det_hist = 4'd0; det_fill = 0; det_hits = 0;
        #1;
        test_reset();
        test_default();
        test_gap();
        test_back_to_back();
        test_stall();
        test_rep15();
        test_err();
        test_abort();
        test_reset_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
